// File: rtl/ps2_pkg.sv
// Shared scancode constants, decoder state encoding and key map for the PS/2 keyboard front end.
package ps2_pkg;

  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXT     = 2'd1,
    S_BRK     = 2'd2,
    S_EXT_BRK = 2'd3
  } dec_state_t;

  typedef struct packed {
    logic w;
    logic a;
    logic s;
    logic d;
    logic enter;
  } keys_t;

  // One-hot mask of the held output a scancode drives; all zero when unmapped.
  function automatic keys_t key_map(input logic [7:0] code, input logic ext);
    keys_t m;
    m = '0;
    if (!ext) begin
      case (code)
        SC_W:     m.w = 1'b1;
        SC_A:     m.a = 1'b1;
        SC_S:     m.s = 1'b1;
        SC_D:     m.d = 1'b1;
        SC_ENTER: m.enter = 1'b1;
        default:  m = '0;
      endcase
    end else begin
      case (code)
        SC_UP:    m.w = 1'b1;
        SC_LEFT:  m.a = 1'b1;
        SC_DOWN:  m.s = 1'b1;
        SC_RIGHT: m.d = 1'b1;
        SC_ENTER: m.enter = 1'b1;
        default:  m = '0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host byte receiver: synchroniser, clock glitch filter,
// 11-bit frame capture with odd-parity check and mid-frame timeout.
module ps2_rx #(
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned FILT_LEN    = 8
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]          clk_sync_q;
  logic [1:0]          dat_sync_q;
  logic [FILT_LEN-1:0] filt_q;
  logic                filt_clk_q;
  logic                fe_q;
  logic [3:0]          bit_cnt_q;
  logic [9:0]          shift_q;
  logic [TW-1:0]       idle_q;
  logic                frame_ok_c;

  // shift_q holds {parity, D7..D0, start}; the stop bit is the live data sample.
  assign frame_ok_c = ~shift_q[0] & dat_sync_q[1] & (^shift_q[9:1]);

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= '1;
      filt_clk_q <= 1'b1;
      fe_q       <= 1'b0;
      bit_cnt_q  <= 4'd0;
      shift_q    <= 10'd0;
      idle_q     <= '0;
      byte_data  <= 8'd0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_in};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_in};
      filt_q     <= {filt_q[FILT_LEN-2:0], clk_sync_q[1]};
      fe_q       <= 1'b0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;

      if (&filt_q) begin
        filt_clk_q <= 1'b1;
      end else if (~|filt_q) begin
        filt_clk_q <= 1'b0;
        fe_q       <= filt_clk_q;
      end

      if (fe_q) begin
        idle_q <= '0;
        if (bit_cnt_q == 4'd10) begin
          bit_cnt_q <= 4'd0;
          if (frame_ok_c) begin
            byte_data  <= shift_q[8:1];
            byte_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end else begin
          shift_q   <= {dat_sync_q[1], shift_q[9:1]};
          bit_cnt_q <= bit_cnt_q + 4'd1;
        end
      end else if (bit_cnt_q != 4'd0) begin
        // Abandon a stalled frame silently so the next edge restarts at a start bit.
        if (idle_q == TW'(TIMEOUT_CYC - 1)) begin
          bit_cnt_q <= 4'd0;
          idle_q    <= '0;
        end else begin
          idle_q <= idle_q + TW'(1);
        end
      end else begin
        idle_q <= '0;
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// Set-2 scancode decoder producing held w/a/s/d/enter levels from a receive-only PS/2 port.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned FILT_LEN    = 8
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       w,
  output logic       a,
  output logic       s,
  output logic       d,
  output logic       enter,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       frame_err
);

  dec_state_t state_q, state_d;
  keys_t      keys_q, keys_d;

  ps2_rx #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .FILT_LEN   (FILT_LEN)
  ) u_rx (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .frame_err (frame_err)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      keys_q  <= '0;
    end else begin
      state_q <= state_d;
      keys_q  <= keys_d;
    end
  end

  // Prefix tracking; unmapped codes still finish the sequence back to S_IDLE.
  always_comb begin
    state_d = state_q;
    keys_d  = keys_q;
    if (byte_valid) begin
      case (state_q)
        S_IDLE: begin
          if (byte_data == SC_EXT)      state_d = S_EXT;
          else if (byte_data == SC_BRK) state_d = S_BRK;
          else keys_d = keys_t'(keys_q | key_map(byte_data, 1'b0));
        end
        S_EXT: begin
          if (byte_data == SC_BRK) begin
            state_d = S_EXT_BRK;
          end else begin
            keys_d  = keys_t'(keys_q | key_map(byte_data, 1'b1));
            state_d = S_IDLE;
          end
        end
        S_BRK: begin
          keys_d  = keys_t'(keys_q & ~key_map(byte_data, 1'b0));
          state_d = S_IDLE;
        end
        S_EXT_BRK: begin
          keys_d  = keys_t'(keys_q & ~key_map(byte_data, 1'b1));
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign w     = keys_q.w;
  assign a     = keys_q.a;
  assign s     = keys_q.s;
  assign d     = keys_q.d;
  assign enter = keys_q.enter;

endmodule
